// File: rtl/xy_point_seq.sv
// Frame-snapshot XY point sequencer: on each frame tick it latches the object
// positions, then emits ball, left paddle and right paddle points, one per point tick.
module xy_point_seq #(
    parameter logic [7:0]  PAD_L_X  = 8'd16,
    parameter logic [7:0]  PAD_R_X  = 8'd239,
    parameter int unsigned PAD_LEN  = 32,
    parameter int unsigned BALL_REP = 4
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       clk_100k,
    input  logic       clk_ctr,
    input  logic [7:0] ball_x,
    input  logic [7:0] ball_y,
    input  logic [7:0] pad_l_y,
    input  logic [7:0] pad_r_y,
    output logic [7:0] dac_x,
    output logic [7:0] dac_y,
    output logic       dac_wr,
    output logic       frame_start,
    output logic       busy,
    output logic       overrun
);
    localparam int unsigned IW = 6;
    localparam logic [IW-1:0] BALL_LAST = IW'(BALL_REP - 1);
    localparam logic [IW-1:0] PAD_LAST  = IW'(PAD_LEN - 1);

    typedef enum logic [1:0] {IDLE, BALL, PAD_L, PAD_R} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [7:0]    bx, by, ly, ry;
    logic          prev_p, prev_f;
    logic          pt_tick, fr_tick;

    assign pt_tick = clk_100k & ~prev_p;
    assign fr_tick = clk_ctr & ~prev_f;

    // Paddle y runs downward from its top; clamp at the screen edge instead of wrapping.
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [IW-1:0] i);
        logic [8:0] s;
        s = 9'(a) + 9'(i);
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    always_ff @(posedge sysclk) begin
        if (rst) begin
            // Track the live levels so a high input at release is not seen as an edge.
            prev_p      <= clk_100k;
            prev_f      <= clk_ctr;
            state       <= IDLE;
            idx         <= '0;
            bx          <= '0;
            by          <= '0;
            ly          <= '0;
            ry          <= '0;
            dac_x       <= '0;
            dac_y       <= '0;
            dac_wr      <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            prev_p      <= clk_100k;
            prev_f      <= clk_ctr;
            dac_wr      <= 1'b0;
            frame_start <= 1'b0;
            if (fr_tick && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (fr_tick) begin
                        bx          <= ball_x;
                        by          <= ball_y;
                        ly          <= pad_l_y;
                        ry          <= pad_r_y;
                        frame_start <= 1'b1;
                        busy        <= 1'b1;
                        idx         <= '0;
                        state       <= BALL;
                    end
                end
                BALL: begin
                    if (pt_tick) begin
                        dac_x  <= bx;
                        dac_y  <= by;
                        dac_wr <= 1'b1;
                        if (idx == BALL_LAST) begin
                            idx   <= '0;
                            state <= PAD_L;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                PAD_L: begin
                    if (pt_tick) begin
                        dac_x  <= PAD_L_X;
                        dac_y  <= sat_add(ly, idx);
                        dac_wr <= 1'b1;
                        if (idx == PAD_LAST) begin
                            idx   <= '0;
                            state <= PAD_R;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                PAD_R: begin
                    if (pt_tick) begin
                        dac_x  <= PAD_R_X;
                        dac_y  <= sat_add(ry, idx);
                        dac_wr <= 1'b1;
                        if (idx == PAD_LAST) begin
                            idx   <= '0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                default: begin
                    idx   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xy_point_seq.sv
// Self-checking bench for xy_point_seq: expected points are queued when a frame
// is launched and compared in order against every dac_wr strobe.
module tb_xy_point_seq;
    localparam int NPTS     = 68;
    localparam int BALL_REP = 4;
    localparam int PAD_LEN  = 32;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } pt_t;

    typedef struct {
        logic [7:0] bx;
        logic [7:0] by;
        logic [7:0] ly;
        logic [7:0] ry;
        logic [7:0] exp_last_ly;
        logic [7:0] exp_last_ry;
    } vec_t;

    logic       sysclk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_100k = 1'b0;
    logic       clk_ctr = 1'b0;
    logic [7:0] ball_x = '0;
    logic [7:0] ball_y = '0;
    logic [7:0] pad_l_y = '0;
    logic [7:0] pad_r_y = '0;
    logic [7:0] dac_x;
    logic [7:0] dac_y;
    logic       dac_wr;
    logic       frame_start;
    logic       busy;
    logic       overrun;

    int  n_tests = 0;
    int  n_fail = 0;
    int  wr_count = 0;
    int  fs_count = 0;
    pt_t exp_q[$];
    pt_t obs_q[$];
    pt_t frame_pts[$];
    vec_t vecs[4];

    xy_point_seq dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .clk_100k   (clk_100k),
        .clk_ctr    (clk_ctr),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .pad_l_y    (pad_l_y),
        .pad_r_y    (pad_r_y),
        .dac_x      (dac_x),
        .dac_y      (dac_y),
        .dac_wr     (dac_wr),
        .frame_start(frame_start),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #10 sysclk = ~sysclk;

    // Capture every strobe and frame pulse on the inactive edge.
    always @(negedge sysclk) begin
        if (dac_wr) begin
            obs_q.push_back({dac_x, dac_y});
            wr_count++;
        end
        if (frame_start) fs_count++;
    end

    task automatic step();
        @(negedge sysclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] sat8(input int v);
        return (v > 255) ? 8'd255 : 8'(v);
    endfunction

    task automatic push_frame(input logic [7:0] bx, input logic [7:0] by,
                              input logic [7:0] ly, input logic [7:0] ry);
        for (int i = 0; i < BALL_REP; i++) exp_q.push_back({bx, by});
        for (int i = 0; i < PAD_LEN; i++) exp_q.push_back({8'd16, sat8(int'(ly) + i)});
        for (int i = 0; i < PAD_LEN; i++) exp_q.push_back({8'd239, sat8(int'(ry) + i)});
    endtask

    task automatic pulse_pt();
        step();
        clk_100k = 1'b1;
        step();
        clk_100k = 1'b0;
        step();
    endtask

    task automatic drain();
        pt_t o;
        pt_t e;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            frame_pts.push_back(o);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL extra_point: got 0x%0h expected no strobe", o);
            end else begin
                e = exp_q.pop_front();
                check("point_xy", 32'(o), 32'(e));
            end
        end
    endtask

    // Launch one frame; optionally change inputs or force an extra frame edge mid-frame.
    task automatic run_frame(input vec_t v, input int chg_at, input int ovr_at, input bool_same);
        int wr0;
        int fs0;
        step();
        ball_x  = v.bx;
        ball_y  = v.by;
        pad_l_y = v.ly;
        pad_r_y = v.ry;
        push_frame(v.bx, v.by, v.ly, v.ry);
        frame_pts.delete();
        wr0 = wr_count;
        fs0 = fs_count;
        step();
        clk_ctr  = 1'b1;
        clk_100k = bool_same;
        step();
        clk_ctr  = 1'b0;
        clk_100k = 1'b0;
        check("frame_start_pulse", 32'(frame_start), 32'd1);
        check("busy_on", 32'(busy), 32'd1);
        for (int i = 0; i < NPTS; i++) begin
            if (i == chg_at) begin
                ball_x  = 8'd7;
                pad_l_y = 8'd99;
            end
            if (i == ovr_at) begin
                clk_ctr = 1'b1;
                step();
                clk_ctr = 1'b0;
                check("overrun_set", 32'(overrun), 32'd1);
            end
            pulse_pt();
        end
        step();
        drain();
        check("strobe_count", 32'(wr_count - wr0), 32'(NPTS));
        check("frame_count", 32'(fs_count - fs0), 32'd1);
        check("busy_off", 32'(busy), 32'd0);
        check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        if (frame_pts.size() == NPTS) begin
            check("last_left_y", 32'(frame_pts[BALL_REP+PAD_LEN-1].y), 32'(v.exp_last_ly));
            check("last_right_y", 32'(frame_pts[NPTS-1].y), 32'(v.exp_last_ry));
        end
        exp_q.delete();
    endtask

    initial begin
        vec_t v;
        int   wr0;

        vecs[0] = '{8'd100, 8'd50,  8'd10,  8'd200, 8'd41,  8'd231};
        vecs[1] = '{8'd0,   8'd0,   8'd0,   8'd240, 8'd31,  8'd255};
        vecs[2] = '{8'd255, 8'd255, 8'd224, 8'd0,   8'd255, 8'd31};
        vecs[3] = '{8'd7,   8'd99,  8'd230, 8'd17,  8'd255, 8'd48};

        // Reset with both levels high: no spurious ticks after release.
        rst      = 1'b1;
        clk_100k = 1'b1;
        clk_ctr  = 1'b1;
        repeat (5) step();
        rst = 1'b0;
        repeat (1000) step();
        check("no_strobe_after_reset", 32'(wr_count), 32'd0);
        check("no_frame_after_reset", 32'(fs_count), 32'd0);
        check("reset_dac_x", 32'(dac_x), 32'd0);
        check("reset_dac_y", 32'(dac_y), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset_frame_start", 32'(frame_start), 32'd0);
        clk_100k = 1'b0;
        clk_ctr  = 1'b0;
        step();
        step();
        obs_q.delete();

        for (int k = 0; k < 4; k++) run_frame(vecs[k], -1, -1, 1'b0);

        // Extra frame edge mid-frame: sticky overrun, no restart.
        run_frame(vecs[0], -1, 20, 1'b0);
        wr0 = wr_count;
        repeat (5) pulse_pt();
        step();
        check("no_restart_after_overrun", 32'(wr_count - wr0), 32'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);
        obs_q.delete();

        // Inputs change at point 2: current frame uses snapshot, next uses 7/99.
        run_frame(vecs[0], 2, -1, 1'b0);
        v = '{8'd7, 8'd50, 8'd99, 8'd200, 8'd130, 8'd231};
        run_frame(v, -1, -1, 1'b0);

        // Frame and point edges in the same idle cycle: snapshot only.
        run_frame(vecs[2], -1, -1, 1'b1);

        // Reset mid-frame at point 40.
        step();
        push_frame(8'd33, 8'd44, 8'd55, 8'd66);
        ball_x  = 8'd33;
        ball_y  = 8'd44;
        pad_l_y = 8'd55;
        pad_r_y = 8'd66;
        step();
        clk_ctr = 1'b1;
        step();
        clk_ctr = 1'b0;
        for (int i = 0; i < 40; i++) pulse_pt();
        step();
        frame_pts.delete();
        drain();
        check("points_before_rst", 32'(frame_pts.size()), 32'd40);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dac_wr", 32'(dac_wr), 32'd0);
        check("rst_dac_x", 32'(dac_x), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        exp_q.delete();
        wr0 = wr_count;
        repeat (5) pulse_pt();
        step();
        check("idle_after_rst", 32'(wr_count - wr0), 32'd0);
        obs_q.delete();
        run_frame(vecs[1], -1, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
